// File: rtl/mode_pkg.sv
// mode_pkg: state codes shared by the vending-machine mode FSM and mode_timer,
// the mode_timer phase enum, and decode helpers.
//   is_timed(code)    : 1 for the display states that end with a finish pulse
//   entry_phase(code) : phase entered when state_q takes on `code`
package mode_pkg;

  localparam logic [3:0] S_OFF         = 4'b0000;
  localparam logic [3:0] S_INQUIRE     = 4'b0001;
  localparam logic [3:0] S_ADD_AMOUNT  = 4'b0011;
  localparam logic [3:0] S_PAYMENT     = 4'b0010;
  localparam logic [3:0] S_SUCCESS     = 4'b0110;
  localparam logic [3:0] S_FAILURE     = 4'b0111;
  localparam logic [3:0] S_ADM1        = 4'b0101;
  localparam logic [3:0] S_ADM2        = 4'b0100;
  localparam logic [3:0] S_ADM3        = 4'b1100;
  localparam logic [3:0] S_ADM_INQUIRE = 4'b1101;
  localparam logic [3:0] S_ADM_ADD     = 4'b1111;
  localparam logic [3:0] S_RESET       = 4'b1110;
  localparam logic [3:0] S_SALE_AMOUNT = 4'b1010;
  localparam logic [3:0] S_SUC_ADM     = 4'b1011;
  localparam logic [3:0] S_WELCOME     = 4'b1001;
  localparam logic [3:0] S_OUT         = 4'b1000;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_DWELL = 2'd1,
    P_DONE  = 2'd2,
    P_AUTO  = 2'd3
  } phase_t;

  function automatic logic is_timed(input logic [3:0] code);
    case (code)
      S_SUCCESS, S_FAILURE, S_RESET, S_SALE_AMOUNT,
      S_SUC_ADM, S_WELCOME, S_OUT: is_timed = 1'b1;
      default:                     is_timed = 1'b0;
    endcase
  endfunction

  function automatic phase_t entry_phase(input logic [3:0] code);
    if (is_timed(code))         entry_phase = P_DWELL;
    else if (code == S_INQUIRE) entry_phase = P_AUTO;
    else                        entry_phase = P_IDLE;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: divides clk down to a one-cycle sec_tick once per second.
//   clk      in  system clock
//   rst_n    in  synchronous active-high reset
//   clear    in  forces the count back to 0 (window restart)
//   sec_tick out 1-cycle pulse while the count sits at CLK_HZ-1
module sec_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic sec_tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == CNT_LAST)) cnt_d = '0;
    else                              cnt_d = cnt_q + 1'b1;
  end

  assign sec_tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst_n) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mode_timer.sv
// mode_timer: timing/selection companion of the vending-machine mode FSM.
// Registers the FSM state code, pulses `finish` DWELL_S seconds after entry
// into a timed display state, and owns the selected product index.
//   clk          in   system clock
//   rst_n        in   synchronous active-high reset
//   state        in   mode FSM state code (mode_pkg S_*)
//   switch_plus  in   debounced next-item level
//   switch_minus in   debounced previous-item level
//   finish       out  one-cycle pulse ending a timed state
//   item_idx     out  selected product
//   remain_s     out  seconds left in the running window, else 0
// Build option: define MODE_TIMER_AUTOSCROLL_EN to make INQUIRE advance the
// index every INQUIRE_S seconds; otherwise INQUIRE only follows the switches.
module mode_timer
  import mode_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DWELL_S   = 3,
  parameter int INQUIRE_S = 5,
  parameter int N_ITEMS   = 8,
  localparam int IDX_W    = $clog2(N_ITEMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       state,
  input  logic             switch_plus,
  input  logic             switch_minus,
  output logic             finish,
  output logic [IDX_W-1:0] item_idx,
  output logic [5:0]       remain_s
);

`ifdef MODE_TIMER_AUTOSCROLL_EN
  localparam logic AUTO_EN = 1'b1;
`else
  localparam logic AUTO_EN = 1'b0;
`endif

  localparam logic [5:0]       DWELL_LEN  = 6'(DWELL_S);
  localparam logic [5:0]       DWELL_LAST = 6'(DWELL_S - 1);
  localparam logic [5:0]       INQ_LEN    = 6'(INQUIRE_S);
  localparam logic [5:0]       INQ_LAST   = 6'(INQUIRE_S - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_ITEMS - 1);

  logic [3:0]       state_q;
  phase_t           phase_q, phase_d;
  logic [5:0]       sec_q, sec_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             plus_prev_q, minus_prev_q;
  logic             plus_edge_q, plus_edge_d;
  logic             minus_edge_q, minus_edge_d;
  logic             finish_q, finish_d;
  logic [5:0]       remain_q, remain_d;

  logic change, manual, advance, pre_clear, sec_tick;

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pre_clear),
    .sec_tick (sec_tick)
  );

  always_comb begin
    change       = (state != state_q);
    // Switch edges are only honoured while browsing in INQUIRE.
    manual       = (phase_q == P_AUTO) && (plus_edge_q || minus_edge_q);
    advance      = 1'b0;
    phase_d      = phase_q;
    sec_d        = sec_q;
    idx_d        = idx_q;
    finish_d     = 1'b0;
    remain_d     = '0;
    plus_edge_d  = switch_plus  & ~plus_prev_q;
    minus_edge_d = switch_minus & ~minus_prev_q;

    // The prescaler only runs while a window is open; restarts realign it.
    pre_clear = change || manual ||
                !((phase_q == P_DWELL) || (AUTO_EN && (phase_q == P_AUTO)));

    // A state change overrides everything else, including a final tick.
    if (change) begin
      phase_d = entry_phase(state);
      sec_d   = '0;
    end else begin
      case (phase_q)
        P_DWELL: begin
          if (sec_tick) begin
            if (sec_q == DWELL_LAST) begin
              finish_d = 1'b1;
              phase_d  = P_DONE;
              sec_d    = '0;
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end
        end
        P_AUTO: begin
          if (manual) begin
            sec_d = '0;
          end else if (AUTO_EN && sec_tick) begin
            if (sec_q == INQ_LAST) begin
              advance = 1'b1;
              sec_d   = '0;
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end
        end
        default: sec_d = '0;
      endcase
    end

    // Manual step beats auto-advance; simultaneous plus+minus cancel out.
    if (state_q == S_OFF) begin
      idx_d = '0;
    end else if (manual) begin
      if (plus_edge_q && !minus_edge_q)
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      else if (minus_edge_q && !plus_edge_q)
        idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
    end else if (advance) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    case (phase_d)
      P_DWELL: remain_d = DWELL_LEN - sec_d;
      P_AUTO:  remain_d = AUTO_EN ? (INQ_LEN - sec_d) : 6'd0;
      default: remain_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= S_OFF;
      phase_q      <= P_IDLE;
      sec_q        <= '0;
      idx_q        <= '0;
      plus_prev_q  <= 1'b0;
      minus_prev_q <= 1'b0;
      plus_edge_q  <= 1'b0;
      minus_edge_q <= 1'b0;
      finish_q     <= 1'b0;
      remain_q     <= '0;
    end else begin
      state_q      <= state;
      phase_q      <= phase_d;
      sec_q        <= sec_d;
      idx_q        <= idx_d;
      plus_prev_q  <= switch_plus;
      minus_prev_q <= switch_minus;
      plus_edge_q  <= plus_edge_d;
      minus_edge_q <= minus_edge_d;
      finish_q     <= finish_d;
      remain_q     <= remain_d;
    end
  end

  assign finish   = finish_q;
  assign item_idx = idx_q;
  assign remain_s = remain_q;

endmodule

// File: tb/tb_mode_timer.sv
// tb_mode_timer: directed bench for mode_timer with a cycle-counting model.
module tb_mode_timer;

  localparam int CLK_HZ    = 10;
  localparam int DWELL_S   = 3;
  localparam int INQUIRE_S = 5;
  localparam int N_ITEMS   = 8;
  localparam int IDX_W     = 3;

`ifdef MODE_TIMER_AUTOSCROLL_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // State codes written out independently of the design package.
  localparam logic [3:0] C_OFF     = 4'b0000;
  localparam logic [3:0] C_INQ     = 4'b0001;
  localparam logic [3:0] C_PAYMENT = 4'b0010;
  localparam logic [3:0] C_SUCCESS = 4'b0110;
  localparam logic [3:0] C_FAILURE = 4'b0111;
  localparam logic [3:0] C_ADM1    = 4'b0101;
  localparam logic [3:0] C_RESET   = 4'b1110;
  localparam logic [3:0] C_WELCOME = 4'b1001;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [3:0]       state = C_OFF;
  logic             switch_plus = 1'b0;
  logic             switch_minus = 1'b0;
  logic             finish;
  logic [IDX_W-1:0] item_idx;
  logic [5:0]       remain_s;

  always #5 clk = ~clk;

  mode_timer #(
    .CLK_HZ(CLK_HZ), .DWELL_S(DWELL_S), .INQUIRE_S(INQUIRE_S), .N_ITEMS(N_ITEMS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state),
    .switch_plus(switch_plus), .switch_minus(switch_minus),
    .finish(finish), .item_idx(item_idx), .remain_s(remain_s)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit timed(input logic [3:0] c);
    return c inside {4'b0110, 4'b0111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  endfunction

  // ---------------- model: counts cycles since entry / window start ----------------
  logic [3:0] m_code = C_OFF;
  int  m_cyc = 0, m_win = 0, m_idx = 0;
  bit  m_done = 0, m_prev_p = 0, m_prev_m = 0, m_pend_p = 0, m_pend_m = 0;
  bit  model_valid = 0;
  logic [31:0] exp_finish = 0, exp_idx = 0, exp_remain = 0;
  logic [3:0] old_code;
  bit chg, man, adv;

  always @(posedge clk) begin
    if (rst_n) begin
      m_code = C_OFF; m_cyc = 0; m_win = 0; m_idx = 0; m_done = 0;
      m_prev_p = 0; m_prev_m = 0; m_pend_p = 0; m_pend_m = 0;
      exp_finish = 0; exp_idx = 0; exp_remain = 0;
      model_valid = 1;
    end else begin
      old_code = m_code;
      chg = (state != old_code);
      man = (old_code == C_INQ) && (m_pend_p || m_pend_m);
      adv = 0;
      exp_finish = 0;
      if (chg) begin
        m_cyc = 0; m_win = 0; m_done = 0;
      end else begin
        if (timed(old_code) && !m_done) begin
          m_cyc++;
          if (m_cyc == DWELL_S * CLK_HZ) begin exp_finish = 1; m_done = 1; end
        end
        if (old_code == C_INQ) begin
          if (man) m_win = 0;
          else if (AUTO) begin
            m_win++;
            if (m_win == INQUIRE_S * CLK_HZ) begin m_win = 0; adv = 1; end
          end
        end
      end
      if (old_code == C_OFF) m_idx = 0;
      else if (man) begin
        if (m_pend_p && !m_pend_m) m_idx = (m_idx + 1) % N_ITEMS;
        else if (m_pend_m && !m_pend_p) m_idx = (m_idx + N_ITEMS - 1) % N_ITEMS;
      end else if (adv) m_idx = (m_idx + 1) % N_ITEMS;
      m_pend_p = switch_plus && !m_prev_p;  m_prev_p = switch_plus;
      m_pend_m = switch_minus && !m_prev_m; m_prev_m = switch_minus;
      m_code = state;
      exp_idx = m_idx;
      if (timed(m_code) && !m_done)        exp_remain = DWELL_S - m_cyc / CLK_HZ;
      else if (m_code == C_INQ && AUTO)    exp_remain = INQUIRE_S - m_win / CLK_HZ;
      else                                 exp_remain = 0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      check("sb_finish", 32'(finish), exp_finish);
      check("sb_item_idx", 32'(item_idx), exp_idx);
      check("sb_remain_s", 32'(remain_s), exp_remain);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_dwell(input logic [3:0] code, input string tag);
    int pulses;
    pulses = 0;
    state = code;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (finish) pulses++;
      check({tag, "_finish"}, 32'(finish), (k == 30) ? 32'd1 : 32'd0);
      case (k)
        0:  check({tag, "_remain0"},  32'(remain_s), 32'd3);
        10: check({tag, "_remain10"}, 32'(remain_s), 32'd2);
        20: check({tag, "_remain20"}, 32'(remain_s), 32'd1);
        30: check({tag, "_remain30"}, 32'(remain_s), 32'd0);
        default: ;
      endcase
    end
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    repeat (3) @(negedge clk);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_idx", 32'(item_idx), 32'd0);
    check("rst_remain", 32'(remain_s), 32'd0);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("off_finish", 32'(finish), 32'd0);
    check("off_remain", 32'(remain_s), 32'd0);

    // SUCCESS dwell, then no repeat pulse.
    run_dwell(C_SUCCESS, "success");
    pulses = 0;
    repeat (100) begin @(negedge clk); if (finish) pulses++; end
    check("success_no_repeat", 32'(pulses), 32'd0);

    // FAILURE aborted at cycle 25 by ADM1.
    state = C_FAILURE;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin @(negedge clk); if (finish) pulses++; end
    state = C_ADM1;
    repeat (20) begin @(negedge clk); if (finish) pulses++; end
    check("failure_aborted", 32'(pulses), 32'd0);
    run_dwell(C_RESET, "reset_state");

    // INQUIRE auto-advance.
    state = C_INQ;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (k == 49 || k == 50 || k == 100 || k == 150)
        check("inq_auto_idx", 32'(item_idx), AUTO ? 32'(k / 50) : 32'd0);
    end

    // Re-enter INQUIRE at index 0, step back with minus.
    state = C_OFF;
    repeat (3) @(negedge clk);
    check("off_clear_idx", 32'(item_idx), 32'd0);
    state = C_INQ;
    repeat (3) @(negedge clk);
    switch_minus = 1'b1;
    @(negedge clk);
    check("minus_lat1", 32'(item_idx), 32'd0);
    @(negedge clk);
    check("minus_wrap", 32'(item_idx), 32'd7);
    check("minus_restart", 32'(remain_s), AUTO ? 32'd5 : 32'd0);
    switch_minus = 1'b0;
    repeat (3) @(negedge clk);
    switch_plus = 1'b1; switch_minus = 1'b1;
    repeat (3) @(negedge clk);
    check("both_edges", 32'(item_idx), 32'd7);
    switch_plus = 1'b0; switch_minus = 1'b0;
    repeat (2) @(negedge clk);

    // Step up to 4 and carry it into PAYMENT, then OFF clears it.
    repeat (5) begin
      switch_plus = 1'b1; @(negedge clk);
      switch_plus = 1'b0; @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("select4", 32'(item_idx), 32'd4);
    state = C_PAYMENT;
    repeat (10) @(negedge clk);
    check("payment_hold", 32'(item_idx), 32'd4);
    state = C_OFF;
    @(negedge clk);
    check("off_k0_hold", 32'(item_idx), 32'd4);
    @(negedge clk);
    check("off_k1_clear", 32'(item_idx), 32'd0);

    // State change on the final tick suppresses finish.
    state = C_FAILURE;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin @(negedge clk); if (finish) pulses++; end
    check("collide_none", 32'(pulses), 32'd0);
    run_dwell(C_WELCOME, "welcome");

    // Reset mid-dwell.
    state = C_SUCCESS;
    repeat (15) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_finish", 32'(finish), 32'd0);
    check("midrst_remain", 32'(remain_s), 32'd0);
    rst_n = 1'b0;
    pulses = 0;
    repeat (45) begin @(negedge clk); if (finish) pulses++; end
    check("midrst_reentry", 32'(pulses), 32'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mode_timer.md
# mode_timer

Timing and selection companion to the vending-machine mode FSM. Consumes the FSM's 4-bit state code, generates the `finish` pulse that ends every timed display state, and owns the selected-item index used in the inquiry and purchase flow. It drives the index and remaining-seconds display, so the mode FSM itself stays purely input-driven.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per second; benches use 10.
- `DWELL_S`, default 3: seconds a timed state is shown before `finish`; range 1–63.
- `INQUIRE_S`, default 5: auto-advance period in S_INQUIRE; range 1–63.
- `N_ITEMS`, default 8: number of products, ≥2; `IDX_W = $clog2(N_ITEMS)`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-high.
- `state`  in  4  mode FSM state code.
- `switch_plus`  in  1  next-item level, already debounced.
- `switch_minus`  in  1  previous-item level, already debounced.
- `finish`  out  1  one-cycle pulse ending a timed state.
- `item_idx`  out  IDX_W  selected product.
- `remain_s`  out  6  seconds left in the current window; 0 when no window is running.

## Operation
- State codes are fixed by the mode FSM:
  - OFF 0000, INQUIRE 0001, ADD_AMOUNT 0011, PAYMENT 0010.
  - SUCCESS 0110, FAILURE 0111, ADM1 0101, ADM2 0100, ADM3 1100.
  - ADM_INQUIRE 1101, ADM_ADD 1111, RESET 1110, SALE_AMOUNT 1010.
  - SUC_ADM 1011, WELCOME 1001, OUT 1000.
- Timed set: SUCCESS, FAILURE, RESET, SALE_AMOUNT, SUC_ADM, WELCOME, OUT.
- `state` is registered into `state_q`. A state change is any cycle where `state != state_q`. A change restarts the prescaler and the seconds counter and returns the phase to its entry point.
- The phase FSM is decoded from `state_q`:
  - P_IDLE: any code outside the timed set and INQUIRE. Counters are held at 0 and `remain_s` is 0.
  - P_DWELL: a timed code. Seconds count up on `sec_tick`. When the count reaches DWELL_S, `finish` pulses once and the phase moves to P_DONE.
  - P_DONE: `finish` stays low and `remain_s` is 0 until the next state change. There is no repeat pulse.
  - P_AUTO: INQUIRE. Every INQUIRE_S seconds, `item_idx` increments.
- Index rules:
  - Increment wraps N_ITEMS-1 → 0. Decrement wraps 0 → N_ITEMS-1.
  - A rising edge of `switch_plus` or `switch_minus` is acted on only in P_AUTO. Each edge moves the index ±1 and restarts the INQUIRE window.
  - If both rising edges occur in the same cycle, the index is unchanged but the window still restarts.
  - A manual edge in the same cycle as an auto-advance overrides the auto-advance; net change is only the manual step.
  - The index holds in all other states, so the selection carries into ADD_AMOUNT and PAYMENT.
  - When `state_q` is OFF, the index clears to 0.
- `remain_s` equals the window length minus the elapsed seconds (DWELL_S or INQUIRE_S), and decrements on each `sec_tick`.
- `state` is sampled only through `state_q`. A code held for a single cycle still causes a change and a restart.

## Timing
- Reset values: `finish`=0, `item_idx`=0, `remain_s`=0, phase P_IDLE, `state_q`=OFF, prescaler=0.
- Latency: all outputs are registered. `state` reaches `state_q` in 1 cycle.
- `finish` rises exactly DWELL_S·CLK_HZ cycles after the first edge at which `state_q` holds the new timed code. It is high for exactly 1 cycle.
- Auto-advance occurs INQUIRE_S·CLK_HZ cycles after INQUIRE entry or after the last manual edge.
- Switch edge to `item_idx` update: 2 cycles (edge register, then index register).
- A state change in the same cycle as the final `sec_tick` wins: no `finish` is produced.
- Reset asserted mid-dwell: `finish` is suppressed, and all outputs return to their reset values on the next edge.

## Configuration
- `MODE_TIMER_AUTOSCROLL_EN` defined: INQUIRE auto-advances as described above.
- Not defined: P_AUTO never auto-advances; only plus/minus change the index, and `remain_s` reads 0 in INQUIRE. P_DWELL behaviour is identical in both builds.

## Structure
- Package `mode_pkg` holds:
  - the 16 state-code localparams;
  - the phase enum (P_IDLE, P_DWELL, P_DONE, P_AUTO);
  - function `is_timed(code)`.
  The mode FSM imports the same package.
- Sub-module `sec_prescaler`: parameter CLK_HZ; inputs `clk`, `rst_n`, `clear`; output `sec_tick`, a 1-cycle pulse at count CLK_HZ-1. `clear` forces the count to 0.

## Test plan
Bench parameters: CLK_HZ=10, DWELL_S=3, INQUIRE_S=5, N_ITEMS=8.
- Reset held 3 cycles, then `state`=OFF → `finish`=0, `item_idx`=0, `remain_s`=0 throughout.
- `state`=SUCCESS held → `finish` high for exactly 1 cycle at 30 cycles after entry; `remain_s` sequence 3,2,1,0; no second pulse after 100 more cycles.
- `state`=FAILURE, then ADM1 at cycle 25 → no `finish`. Then RESET → `finish` at 30 cycles after RESET entry.
- `state`=INQUIRE for 160 cycles with autoscroll → `item_idx` 0→1→2→3 at cycles 50, 100, 150.
- INQUIRE with `item_idx`=0, `switch_minus` edge → `item_idx`=7, window restarts. Then both switches rise together → index stays 7.
- Select `item_idx`=4, go to PAYMENT then OFF → index holds 4 in PAYMENT and clears to 0 one cycle after OFF is registered.
